// File: rtl/pipe_hold_ctrl_pkg.sv
// pipe_hold_ctrl_pkg: hold codes, jump causes and FSM states shared by the hold controller
package pipe_hold_ctrl_pkg;
  localparam int HOLD_W = 2;
  localparam logic [HOLD_W-1:0] HOLD_NO    = 2'd0;
  localparam logic [HOLD_W-1:0] HOLD_WAIT  = 2'd1;
  localparam logic [HOLD_W-1:0] HOLD_FLUSH = 2'd2;
  localparam int JC_NO              = 0;
  localparam int JC_PRED_YES_BUT_NO = 1;
  localparam int JC_PRED_NO_BUT_YES = 2;
  localparam int JC_NOCOND          = 3;
  localparam int JC_IRQ             = 4;
  localparam logic REQ_EN = 1'b1;
  typedef enum logic [1:0] {RUN, IRQ_DRAIN, HALT_DRAIN, HALTED} state_e;
  function automatic logic is_jump(input int unsigned c);
    return c == JC_PRED_YES_BUT_NO || c == JC_PRED_NO_BUT_YES || c == JC_NOCOND;
  endfunction
endpackage

// File: rtl/pipe_hold_ctrl_vec.sv
// pipe_hold_vec: turns the wait vector, flush mask and pc hold into per-stage hold codes
module pipe_hold_vec
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int NSTAGE = 4
) (
  input  logic [NSTAGE-1:0]        wait_req,
  input  logic [NSTAGE-1:0]        flush_mask,
  input  logic                     hold_pc,
  input  logic                     hold_all,
  output logic [HOLD_W*NSTAGE-1:0] hold_ctrl
);
  logic [NSTAGE-1:0] above;
  logic [NSTAGE-1:0] bubble;
  assign bubble = {above[NSTAGE-2:0], 1'b0} & ~above;
  // a stage waits when it or any older stage waits; the stage just past the oldest waiter gets a bubble
  always_comb begin
    above = '0;
    hold_ctrl = '0;
    for (int s = 0; s < NSTAGE; s++) above[s] = |(wait_req >> s);
    for (int s = 0; s < NSTAGE; s++)
      hold_ctrl[HOLD_W*s +: HOLD_W] = above[s] ? HOLD_WAIT :
                                      bubble[s] ? HOLD_FLUSH :
                                      above[0] ? HOLD_NO :
                                      hold_all ? HOLD_WAIT :
                                      (s == 0 && hold_pc) ? HOLD_WAIT :
                                      flush_mask[s] ? HOLD_FLUSH : HOLD_NO;
  end
endmodule

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: pipeline hold/flush, interrupt entry and debug halt control; CTRL_PERF_CNT_EN adds stall/flush counters
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int NSTAGE   = 4,
  parameter int ADDR_W   = 32,
  parameter int CAUSE_W  = 3,
  parameter int EX_STAGE = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NSTAGE-1:0]        wait_req_i,
  input  logic [CAUSE_W-1:0]       jump_cause_i,
  input  logic [ADDR_W-1:0]        jump_from_addr_i,
  input  logic [ADDR_W-1:0]        jump_to_addr_i,
  input  logic [ADDR_W-1:0]        ex_pc_i,
  input  logic                     irq_req_i,
  input  logic [ADDR_W-1:0]        irq_vector_i,
  input  logic                     halt_req_i,
  output logic [HOLD_W*NSTAGE-1:0] hold_ctrl_o,
  output logic [CAUSE_W-1:0]       jump_cause_o,
  output logic [ADDR_W-1:0]        jump_from_addr_o,
  output logic [ADDR_W-1:0]        jump_to_addr_o,
  output logic                     irq_ack_o,
  output logic [ADDR_W-1:0]        irq_epc_o,
  output logic                     halted_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cycles_o,
  output logic [31:0]              flush_events_o
`endif
);
  localparam int CNT_W = $clog2(NSTAGE) + 1;
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(NSTAGE - 1 - EX_STAGE);
  localparam logic [NSTAGE-1:0] EX_MASK = ((NSTAGE'(1) << (EX_STAGE + 1)) - NSTAGE'(1)) & ~NSTAGE'(1);
  state_e state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] epc_nx;
  logic [HOLD_W*NSTAGE-1:0] vec_hold;
  logic stall, jmp_v, draining, irq_on, halt_on, jmp_go, irq_go, drain_jmp;
  assign stall     = |wait_req_i;
  assign jmp_v     = is_jump(32'(jump_cause_i));
  assign draining  = state == IRQ_DRAIN || state == HALT_DRAIN;
  assign irq_on    = irq_req_i == REQ_EN;
  assign halt_on   = halt_req_i == REQ_EN;
  assign jmp_go    = !rst && !stall && jmp_v;
  assign irq_go    = !rst && !stall && !jmp_v && state == IRQ_DRAIN && cnt == '0;
  assign drain_jmp = jmp_v && state == IRQ_DRAIN;
  pipe_hold_vec #(.NSTAGE(NSTAGE)) u_vec (
    .wait_req  (rst ? '0 : wait_req_i),
    .flush_mask((jmp_v || draining) ? EX_MASK : '0),
    .hold_pc   (jmp_v || draining),
    .hold_all  (state == HALTED),
    .hold_ctrl (vec_hold)
  );
  assign hold_ctrl_o      = rst ? {NSTAGE{HOLD_FLUSH}} : vec_hold;
  assign jump_cause_o     = jmp_go ? jump_cause_i : irq_go ? CAUSE_W'(JC_IRQ) : CAUSE_W'(JC_NO);
  assign jump_from_addr_o = jmp_go ? jump_from_addr_i : irq_go ? irq_epc_o : '0;
  assign jump_to_addr_o   = jmp_go ? jump_to_addr_i : irq_go ? irq_vector_i : '0;
  assign irq_ack_o        = irq_go;
  assign halted_o         = state == HALTED;
  // sequencing: everything freezes on a wait; a jump in RUN blocks entry, a jump at the final drain count defers the irq redirect
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    epc_nx = irq_epc_o;
    if (!stall) begin
      if (state == RUN && !jmp_v && irq_on) begin
        state_nx = IRQ_DRAIN;
        cnt_nx = DRAIN_LD;
        epc_nx = ex_pc_i;
      end else if (state == RUN && !jmp_v && halt_on) begin
        state_nx = HALT_DRAIN;
        cnt_nx = DRAIN_LD;
      end else if (draining) begin
        cnt_nx = cnt == '0 ? cnt : cnt - CNT_W'(1);
        epc_nx = drain_jmp ? jump_to_addr_i : irq_epc_o;
        state_nx = (cnt != '0 || drain_jmp) ? state : state == IRQ_DRAIN ? RUN : HALTED;
      end else if (state == HALTED && !halt_on) begin
        state_nx = RUN;
      end
    end
  end
  // state, drain counter and return address registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      irq_epc_o <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      irq_epc_o <= epc_nx;
    end
  end
`ifdef CTRL_PERF_CNT_EN
  logic stall_inc, flush_inc;
  assign stall_inc = !rst && (stall || state == HALTED);
  assign flush_inc = jmp_go || irq_go;
  // saturating stall-cycle and redirect counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_o <= '0;
      flush_events_o <= '0;
    end else begin
      stall_cycles_o <= stall_cycles_o + 32'(stall_inc && !(&stall_cycles_o));
      flush_events_o <= flush_events_o + 32'(flush_inc && !(&flush_events_o));
    end
  end
`endif
endmodule
